// File: rtl/galvo_pkg.sv
// galvo_pkg: shared definitions for the galvo point pacer.
//   - speed select codes for the `setting` input
//   - pacer FSM state encoding
//   - default geometry, period and dwell values
package galvo_pkg;

   localparam logic [1:0] SPD_SLOW = 2'd0;
   localparam logic [1:0] SPD_MED1 = 2'd1;
   localparam logic [1:0] SPD_MED2 = 2'd2;
   localparam logic [1:0] SPD_FAST = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DWELL = 2'd2
   } pacer_state_t;

   localparam int DEF_XY_W  = 12;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_SLOW  = 3600;
   localparam int DEF_MED1  = 2500;
   localparam int DEF_MED2  = 2000;
   localparam int DEF_FAST  = 1700;
   localparam int DEF_DWELL = 900;

endpackage

// File: rtl/galvo_point_pacer_if.sv
// galvo_point_pacer_if: upstream point stream (x, y, laser) with valid/ready.
//   pt_valid  source -> pacer   point available
//   pt_x/pt_y source -> pacer   DAC coordinates, XY_W bits each
//   pt_laser  source -> pacer   laser on for this point
//   pt_ready  pacer  -> source  point taken this cycle when pt_valid is high
interface galvo_point_pacer_if #(
   parameter int XY_W = 12
);
   logic            pt_valid;
   logic [XY_W-1:0] pt_x;
   logic [XY_W-1:0] pt_y;
   logic            pt_laser;
   logic            pt_ready;

   modport master (output pt_valid, pt_x, pt_y, pt_laser, input  pt_ready);
   modport slave  (input  pt_valid, pt_x, pt_y, pt_laser, output pt_ready);
endinterface

// File: rtl/galvo_interval_counter.sv
// galvo_interval_counter: point-rate interval timer.
//   clk, reset   clock and synchronous active-high reset
//   count_en     pacer is in RUN; counter advances
//   clear        pacer is in IDLE; counter parked at 0
//   setting      speed select, sampled only at a tick
//   tick         interval boundary (counting and cnt == 0)
// cnt runs 0..period_q and wraps; period_q is reloaded only at a tick, so a
// mid-interval speed change lands on the following interval. Outside RUN and
// IDLE the count holds, which lets a dwell resume the interval at cnt=1.
module galvo_interval_counter
   import galvo_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int SLOW  = DEF_SLOW,
   parameter int MED1  = DEF_MED1,
   parameter int MED2  = DEF_MED2,
   parameter int FAST  = DEF_FAST
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       count_en,
   input  logic       clear,
   input  logic [1:0] setting,
   output logic       tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] period_sel;
   logic [CNT_W-1:0] limit;

   always_comb begin
      period_sel = CNT_W'(SLOW);
      case (setting)
         SPD_MED1: period_sel = CNT_W'(MED1);
         SPD_MED2: period_sel = CNT_W'(MED2);
         SPD_FAST: period_sel = CNT_W'(FAST);
         default:  period_sel = CNT_W'(SLOW);
      endcase
   end

   assign tick  = count_en && (cnt == '0);
   // At a tick the new period already governs the step out of 0.
   assign limit = tick ? period_sel : period_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         period_q <= CNT_W'(SLOW);
      end else begin
         if (tick) period_q <= period_sel;
         if (clear)
            cnt <= '0;
         else if (count_en)
            cnt <= (cnt >= limit) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/galvo_point_pacer.sv
// galvo_point_pacer: paces an upstream point stream into the galvo DAC.
//   clk, reset        clock and synchronous active-high reset
//   enable            run pacing; low forces IDLE with the laser blanked
//   setting           speed select (SLOW/MED1/MED2/FAST)
//   pt                point stream, slave side (pt_ready is combinational)
//   dac_x, dac_y      registered coordinates to the DAC
//   laser_on          registered laser enable
//   strobe_out        one-cycle DAC load strobe after an accepted point
//   underrun          one-cycle pulse after a tick with no point available
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not pacing; laser off, DAC holds, interval counter parked
// ST_RUN   | interval counter running; a point is taken at each tick
// ST_DWELL | settling after a laser change; laser_tgt applied at the end
module galvo_point_pacer
   import galvo_pkg::*;
#(
   parameter int XY_W  = DEF_XY_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int SLOW  = DEF_SLOW,
   parameter int MED1  = DEF_MED1,
   parameter int MED2  = DEF_MED2,
   parameter int FAST  = DEF_FAST,
   parameter int DWELL = DEF_DWELL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          setting,
   galvo_point_pacer_if.slave  pt,
   output logic [XY_W-1:0]     dac_x,
   output logic [XY_W-1:0]     dac_y,
   output logic                laser_on,
   output logic                strobe_out,
   output logic                underrun
);

   // Dwell timer is a down-counter: loaded with DWELL-1, done at 0.
   localparam logic [CNT_W-1:0] DWELL_LAST = (DWELL > 0) ? CNT_W'(DWELL - 1) : '0;

   pacer_state_t     state, state_d;
   logic [CNT_W-1:0] dcnt, dcnt_d;
   logic             laser_tgt, tgt_d;
   logic [XY_W-1:0]  dac_x_d, dac_y_d;
   logic             laser_d, strobe_d, underrun_d;
   logic             tick;

   galvo_interval_counter #(
      .CNT_W (CNT_W),
      .SLOW  (SLOW),
      .MED1  (MED1),
      .MED2  (MED2),
      .FAST  (FAST)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .count_en (state == ST_RUN),
      .clear    (state == ST_IDLE),
      .setting  (setting),
      .tick     (tick)
   );

   // Gated so a point is never taken on a cycle whose result is discarded.
   assign pt.pt_ready = tick & enable & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         dcnt       <= '0;
         laser_tgt  <= 1'b0;
         dac_x      <= '0;
         dac_y      <= '0;
         laser_on   <= 1'b0;
         strobe_out <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_d;
         dcnt       <= dcnt_d;
         laser_tgt  <= tgt_d;
         dac_x      <= dac_x_d;
         dac_y      <= dac_y_d;
         laser_on   <= laser_d;
         strobe_out <= strobe_d;
         underrun   <= underrun_d;
      end
   end

   always_comb begin
      state_d    = state;
      dcnt_d     = dcnt;
      tgt_d      = laser_tgt;
      dac_x_d    = dac_x;
      dac_y_d    = dac_y;
      laser_d    = laser_on;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         laser_d = 1'b0;
      end else begin
         case (state)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
               if (tick) begin
                  if (pt.pt_valid) begin
                     dac_x_d  = pt.pt_x;
                     dac_y_d  = pt.pt_y;
                     strobe_d = 1'b1;
                     if (pt.pt_laser != laser_on) begin
                        if (DWELL == 0) begin
                           laser_d = pt.pt_laser;
                        end else begin
                           // Blank now; an unblank waits for the dwell to end.
                           laser_d = 1'b0;
                           tgt_d   = pt.pt_laser;
                           dcnt_d  = DWELL_LAST;
                           state_d = ST_DWELL;
                        end
                     end
                  end else begin
                     underrun_d = 1'b1;
                     laser_d    = 1'b0;
                  end
               end
            end
            ST_DWELL: begin
               if (dcnt == '0) begin
                  state_d = ST_RUN;
                  laser_d = laser_tgt;
               end else begin
                  dcnt_d = dcnt - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_galvo_point_pacer.sv
// tb_galvo_point_pacer: self-checking bench for galvo_point_pacer.
// Accepted points and underruns are pushed to a scoreboard when the tick is
// seen; the DAC/strobe/underrun outputs are popped and compared a cycle later.
module tb_galvo_point_pacer;
   import galvo_pkg::*;

   localparam int XY_W  = 12;
   localparam int CNT_W = 16;
   localparam int SLOW  = 9;
   localparam int MED1  = 7;
   localparam int MED2  = 5;
   localparam int FAST  = 3;
   localparam int DWELL = 4;

   typedef struct {
      bit              und;
      logic [XY_W-1:0] x;
      logic [XY_W-1:0] y;
      int              cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [1:0]      setting;
   logic [XY_W-1:0] dac_x, dac_y;
   logic            laser_on, strobe_out, underrun;

   galvo_point_pacer_if #(.XY_W(XY_W)) pt_if ();

   galvo_point_pacer #(
      .XY_W(XY_W), .CNT_W(CNT_W), .SLOW(SLOW), .MED1(MED1),
      .MED2(MED2), .FAST(FAST), .DWELL(DWELL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .setting    (setting),
      .pt         (pt_if),
      .dac_x      (dac_x),
      .dac_y      (dac_y),
      .laser_on   (laser_on),
      .strobe_out (strobe_out),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int              checks   = 0;
   int              failures = 0;
   exp_t            sb[$];
   logic [XY_W-1:0] exp_x, exp_y;
   bit              acc_prev;
   bit              nx_laser;
   int              last_tick;

   // One clock: scoreboard compare, upstream data advance, tick detection.
   task automatic cycle(output bit tick);
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++; failures++;
         $display("FAIL sb_missing: no output by cycle %0d, required at cycle %0d", cyc, sb[0].cyc);
         e = sb.pop_front();
      end
      if (strobe_out === 1'b1 || underrun === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: strobe=%b underrun=%b at cycle %0d, none required",
                     strobe_out, underrun, cyc);
         end else begin
            e = sb.pop_front();
            if (underrun !== e.und || strobe_out !== !e.und || dac_x !== e.x ||
                dac_y !== e.y || cyc != e.cyc) begin
               failures++;
               $display("FAIL sb_output: got und=%b stb=%b x=%h y=%h cyc=%0d, required und=%b stb=%b x=%h y=%h cyc=%0d",
                        underrun, strobe_out, dac_x, dac_y, cyc, e.und, !e.und, e.x, e.y, e.cyc);
            end
         end
      end
      if (acc_prev) begin
         pt_if.pt_x     = pt_if.pt_x + 12'h011;
         pt_if.pt_y     = pt_if.pt_y + 12'h022;
         pt_if.pt_laser = nx_laser;
         acc_prev       = 1'b0;
      end
      tick = (pt_if.pt_ready === 1'b1);
      if (tick) begin
         e.cyc = cyc + 1;
         if (pt_if.pt_valid) begin
            e.und = 1'b0; e.x = pt_if.pt_x; e.y = pt_if.pt_y;
            exp_x = pt_if.pt_x; exp_y = pt_if.pt_y;
            acc_prev = 1'b1;
         end else begin
            e.und = 1'b1; e.x = exp_x; e.y = exp_y;
         end
         sb.push_back(e);
         last_tick = cyc;
      end
   endtask

   task automatic wait_tick(input int budget, output bit ok);
      bit t;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         cycle(t);
         if (t) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit t;
      reset = 1'b1; enable = 1'b0; setting = SPD_FAST;
      pt_if.pt_valid = 1'b0; pt_if.pt_x = '0; pt_if.pt_y = '0; pt_if.pt_laser = 1'b0;
      exp_x = '0; exp_y = '0; acc_prev = 1'b0; nx_laser = 1'b0;
      cycle(t); cycle(t);
      checks++;
      if (dac_x !== 12'h0 || dac_y !== 12'h0 || laser_on !== 1'b0 ||
          strobe_out !== 1'b0 || underrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: x=%h y=%h laser=%b stb=%b und=%b, required all 0",
                  dac_x, dac_y, laser_on, strobe_out, underrun);
      end
      checks++;
      if (pt_if.pt_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready: pt_ready=%b, required 0", pt_if.pt_ready);
      end
      reset = 1'b0;
      cycle(t);
      checks++;
      if (pt_if.pt_ready !== 1'b0 || laser_on !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: ready=%b laser=%b, required 0 0", pt_if.pt_ready, laser_on);
      end
   endtask

   task automatic test_fast_stream();
      bit t, ok;
      int c0, prev, n;
      setting = SPD_FAST;
      pt_if.pt_valid = 1'b1; pt_if.pt_laser = 1'b0; nx_laser = 1'b0;
      pt_if.pt_x = 12'h100; pt_if.pt_y = 12'h200;
      c0 = cyc;
      enable = 1'b1;
      wait_tick(10, ok);
      checks++;
      if (!ok || last_tick != c0 + 1) begin
         failures++;
         $display("FAIL first_tick: tick at cycle %0d (found=%b), required %0d", last_tick, ok, c0 + 1);
      end
      prev = last_tick; n = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(t);
         checks++;
         if (laser_on !== 1'b0) begin
            failures++; $display("FAIL fast_laser: laser_on=%b at cycle %0d, required 0", laser_on, cyc);
         end
         if (t) begin
            checks++;
            if (cyc - prev != FAST + 1) begin
               failures++; $display("FAIL fast_interval: got %0d clocks, required %0d", cyc - prev, FAST + 1);
            end
            prev = cyc; n++;
         end
      end
      checks++;
      if (n != 4) begin
         failures++; $display("FAIL fast_count: got %0d ticks, required 4", n);
      end
   endtask

   task automatic test_setting_change();
      bit t, ok;
      int a, b;
      setting = SPD_SLOW;
      wait_tick(20, ok);
      a = cyc;
      for (int k = 1; k <= 6; k++) begin
         cycle(t);
         checks++;
         if (t) begin
            failures++; $display("FAIL slow_early_tick: tick at +%0d, required none before +10", k);
         end
      end
      setting = SPD_FAST;
      wait_tick(20, ok);
      checks++;
      if (!ok || cyc - a != SLOW + 1) begin
         failures++; $display("FAIL slow_interval: got %0d clocks, required %0d", cyc - a, SLOW + 1);
      end
      b = cyc;
      wait_tick(20, ok);
      checks++;
      if (!ok || cyc - b != FAST + 1) begin
         failures++; $display("FAIL switched_interval: got %0d clocks, required %0d", cyc - b, FAST + 1);
      end
   endtask

   task automatic test_dwell();
      bit t, ok;
      cycle(t);
      pt_if.pt_x = 12'h123; pt_if.pt_y = 12'h456; pt_if.pt_laser = 1'b1; nx_laser = 1'b0;
      wait_tick(10, ok);
      for (int k = 1; k <= 8; k++) begin
         cycle(t);
         if (k == 1) begin
            checks++;
            if (dac_x !== 12'h123) begin
               failures++; $display("FAIL unblank_dac: dac_x=%h, required 123", dac_x);
            end
         end
         checks++;
         if (laser_on !== (k >= 5)) begin
            failures++; $display("FAIL unblank_laser: laser_on=%b at T+%0d, required %b", laser_on, k, k >= 5);
         end
         checks++;
         if (t !== (k == 8)) begin
            failures++; $display("FAIL unblank_tick: tick=%b at T+%0d, required %b", t, k, k == 8);
         end
      end
      for (int k = 1; k <= 8; k++) begin
         cycle(t);
         checks++;
         if (laser_on !== 1'b0) begin
            failures++; $display("FAIL blank_laser: laser_on=%b at U+%0d, required 0", laser_on, k);
         end
         checks++;
         if (t !== (k == 8)) begin
            failures++; $display("FAIL blank_tick: tick=%b at U+%0d, required %b", t, k, k == 8);
         end
      end
   endtask

   task automatic test_underrun();
      bit t, ok;
      int v;
      v = cyc;
      nx_laser = 1'b1;
      wait_tick(10, ok);
      checks++;
      if (!ok || cyc - v != FAST + 1) begin
         failures++; $display("FAIL plain_interval: got %0d clocks, required %0d", cyc - v, FAST + 1);
      end
      for (int k = 1; k <= 8; k++) begin
         cycle(t);
         if (k == 5) begin
            checks++;
            if (laser_on !== 1'b1) begin
               failures++; $display("FAIL lit_before_underrun: laser_on=%b, required 1", laser_on);
            end
         end
         if (k == 6) pt_if.pt_valid = 1'b0;
         checks++;
         if (t !== (k == 8)) begin
            failures++; $display("FAIL pre_underrun_tick: tick=%b at +%0d, required %b", t, k, k == 8);
         end
      end
      cycle(t);
      checks++;
      if (underrun !== 1'b1 || laser_on !== 1'b0 || strobe_out !== 1'b0 || dac_x !== exp_x) begin
         failures++;
         $display("FAIL underrun_outputs: und=%b laser=%b stb=%b x=%h, required 1 0 0 %h",
                  underrun, laser_on, strobe_out, dac_x, exp_x);
      end
      pt_if.pt_valid = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         cycle(t);
         checks++;
         if (t !== (k == 4)) begin
            failures++; $display("FAIL underrun_interval: tick=%b at +%0d, required %b", t, k, k == 4);
         end
      end
      for (int k = 1; k <= 5; k++) begin
         cycle(t);
         checks++;
         if (laser_on !== (k == 5)) begin
            failures++; $display("FAIL relight_dwell: laser_on=%b at +%0d, required %b", laser_on, k, k == 5);
         end
      end
   endtask

   task automatic test_enable_drop();
      bit t, ok;
      pt_if.pt_laser = 1'b0; nx_laser = 1'b1;
      wait_tick(10, ok);
      wait_tick(12, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL drop_setup: no unblank tick found, required one");
      end
      cycle(t); cycle(t);
      enable = 1'b0;
      for (int k = 3; k <= 7; k++) begin
         cycle(t);
         checks++;
         if (t !== 1'b0 || laser_on !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle: tick=%b laser=%b at Z+%0d, required 0 0", t, laser_on, k);
         end
      end
      enable = 1'b1;
      cycle(t);
      checks++;
      if (t !== 1'b1) begin
         failures++; $display("FAIL reenable_tick: tick=%b on first RUN cycle, required 1", t);
      end
   endtask

   task automatic test_reset_mid();
      bit t;
      for (int k = 1; k <= 6; k++) begin
         cycle(t);
         if (k == 5) begin
            checks++;
            if (laser_on !== 1'b1) begin
               failures++; $display("FAIL pre_reset_laser: laser_on=%b, required 1", laser_on);
            end
         end
      end
      reset = 1'b1; enable = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         cycle(t);
         checks++;
         if (dac_x !== 12'h0 || dac_y !== 12'h0 || laser_on !== 1'b0 || strobe_out !== 1'b0 ||
             underrun !== 1'b0 || pt_if.pt_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: x=%h y=%h laser=%b stb=%b und=%b ready=%b, required all 0",
                     dac_x, dac_y, laser_on, strobe_out, underrun, pt_if.pt_ready);
         end
      end
      reset = 1'b0;
      cycle(t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fast_stream();
      test_setting_change();
      test_dwell();
      test_underrun();
      test_enable_drop();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL sb_leftover: %0d outputs never seen, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
